// File: rtl/limn2600_pkg.sv
// Shared types and widths for the limn2600 word-copy DMA engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package limn2600_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int PTR_W      = ADDR_W - 2;   // word pointer, byte offset dropped

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/limn2600_bus_master.sv
// Owns the registered memory-bus outputs and detects transfer completion.
// Latency: issue at edge N drives req/we/addr/data_out after edge N; complete is combinational (req & rdy).
// Backpressure: outputs hold stable while req=1 until rdy; rdy is ignored while req=0.
// Ports: clk, rst (async active-low); issue/issue_we/issue_addr/issue_data load a new transfer;
//        complete flags the edge a transfer finishes; req/we/addr/data_out drive the memory.
module limn2600_bus_master
    import limn2600_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_data,
    input  logic              rdy,
    output logic              complete,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    assign complete = req & rdy;

    // A new issue may coincide with the completion of the previous transfer,
    // so issue takes priority and req stays high across back-to-back transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req      <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            data_out <= '0;
        end else if (issue) begin
            req  <= 1'b1;
            we   <= issue_we;
            addr <= issue_addr;
            // Reads leave the last write data in place.
            if (issue_we) begin
                data_out <= issue_data;
            end
        end else if (complete) begin
            req <= 1'b0;
            we  <= 1'b0;
        end
    end

endmodule

// File: rtl/limn2600_dma.sv
// Word-by-word memory copy engine: read src word, write it to dst, repeat len times.
// Latency: req visible after the start edge; 2 cycles per word with rdy high, done in cycle 2*len+1.
// Backpressure: each transfer waits on rdy; abort ends the copy after the current write.
// Ports: clk, rst (async active-low); start/src/dst/len request a copy; abort stops early;
//        busy/done report status; req/we/addr/data_out/data_in/rdy form the memory bus.
module limn2600_dma
    import limn2600_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rdy
);

    state_t              state, next_state;
    logic [PTR_W-1:0]    src_ptr, dst_ptr;
    logic [PTR_W-1:0]    src_inc;
    logic [LEN_W-1:0]    count;
    logic [DATA_W-1:0]   hold;
    logic                abort_flag;
    logic                abort_pend;
    logic                complete;
    logic                issue, issue_we;
    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]   issue_data;

    // Byte-offset bits of the addresses carry no meaning for word copies.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src[1:0], dst[1:0]};

    assign busy       = (state == RD) || (state == WR);
    assign done       = (state == DONE);
    assign src_inc    = src_ptr + 30'd1;
    // An abort arriving in the same cycle as the final write handshake still counts.
    assign abort_pend = abort_flag | abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state plus bus issue strobes; the next transfer is issued on the
    // same edge that completes the current one.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        next_state = RD;
                        issue      = 1'b1;
                        issue_addr = {src[ADDR_W-1:2], 2'b00};
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            RD: begin
                if (complete) begin
                    next_state = WR;
                    issue      = 1'b1;
                    issue_we   = 1'b1;
                    issue_addr = {dst_ptr, 2'b00};
                    issue_data = data_in;      // same value hold captures this edge
                end
            end
            WR: begin
                if (complete) begin
                    if ((count == 16'd1) || abort_pend) begin
                        next_state = DONE;
                    end else begin
                        next_state = RD;
                        issue      = 1'b1;
                        issue_addr = {src_inc, 2'b00};
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            count      <= '0;
            hold       <= '0;
            abort_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        src_ptr    <= src[ADDR_W-1:2];
                        dst_ptr    <= dst[ADDR_W-1:2];
                        count      <= len;
                        abort_flag <= 1'b0;
                    end
                end
                RD: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (complete) begin
                        hold <= data_in;
                    end
                end
                WR: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (complete) begin
                        src_ptr <= src_inc;
                        dst_ptr <= dst_ptr + 30'd1;
                        count   <= count - 16'd1;
                    end
                end
                DONE: begin
                    abort_flag <= 1'b0;
                end
                default: begin
                    abort_flag <= 1'b0;
                end
            endcase
        end
    end

    limn2600_bus_master u_bus (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .issue_data (issue_data),
        .rdy        (rdy),
        .complete   (complete),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .data_out   (data_out)
    );

endmodule

// File: tb/tb_limn2600_dma.sv
module tb_limn2600_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic        busy, done, req, we;
    logic [31:0] addr, data_out, data_in;
    logic        rdy = 1'b1;

    int n_pass = 0;
    int n_total = 0;

    // Memory model: word i above addr_base reads as data_base + i.
    logic [31:0] addr_base = '0;
    logic [31:0] data_base = '0;
    assign data_in = data_base + ((addr - addr_base) >> 2);

    // Transfer log and rdy generator.
    bit          rdy_mode = 1'b0;   // 0: rdy high, 1: complete on 3rd cycle of req
    int          rcnt = 0;
    bit          q_we[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          stab_cmp = 0;
    int          stab_bad = 0;
    logic        p_req = 1'b0, p_we = 1'b0, p_done = 1'b0;
    logic [31:0] p_addr = '0, p_dout = '0;

    always #5 clk = ~clk;

    limn2600_dma dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .rdy      (rdy)
    );

    always @(negedge clk) begin
        if (rdy_mode) begin
            if (req) begin
                rcnt++;
                rdy = (rcnt == 3);
                if (rdy) rcnt = 0;
            end else begin
                rcnt = 0;
                rdy  = 1'b0;
            end
        end else begin
            rdy = 1'b1;
        end
        if (req && p_req && !p_done) begin
            stab_cmp++;
            if (addr !== p_addr || we !== p_we || data_out !== p_dout) stab_bad++;
        end
        p_req  = req;
        p_addr = addr;
        p_we   = we;
        p_dout = data_out;
        p_done = req && rdy;
        if (req && rdy) begin
            q_we.push_back(we);
            q_addr.push_back(addr);
            q_data.push_back(we ? data_out : data_in);
        end
    end

    // Starts a copy and samples busy/done/req in cycles 1..ncyc (bit k = cycle k).
    // abort is pulsed for one cycle after sampling cycle abort_at.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                       input int ncyc, input int abort_at,
                       output logic [31:0] bm, output logic [31:0] dm, output logic [31:0] rm);
        q_we.delete();
        q_addr.delete();
        q_data.delete();
        stab_cmp = 0;
        stab_bad = 0;
        bm = '0;
        dm = '0;
        rm = '0;
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) @(negedge clk);
            bm[k] = busy;
            dm[k] = done;
            rm[k] = req;
            abort = (k == abort_at);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        n_total++;
        if ({busy, done, req, we} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, req, we});
        else n_pass++;
        n_total++;
        if (addr !== 32'h0 || data_out !== 32'h0) $display("FAIL reset_bus: got addr=%h data_out=%h expected 0/0", addr, data_out);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_copy;
        logic [31:0] bm, dm, rm;
        logic [31:0] ea [6];
        logic [31:0] ed [6];
        bit          ew [6];
        ea = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
        ed = '{32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA2};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        addr_base = 32'h100; data_base = 32'hA0;
        run(32'h100, 32'h200, 16'd3, 9, 0, bm, dm, rm);
        n_total++;
        if (bm !== 32'h7E) $display("FAIL basic_busy: got %h expected 0000007e", bm);
        else n_pass++;
        n_total++;
        if (dm !== 32'h80) $display("FAIL basic_done: got %h expected 00000080", dm);
        else n_pass++;
        n_total++;
        if (q_addr.size() != 6) $display("FAIL basic_count: got %0d expected 6", q_addr.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
            n_total++;
            if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_we[i] !== ew[i])
                $display("FAIL basic_xfer%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         i, q_we[i], q_addr[i], q_data[i], ew[i], ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rdy_wait;
        logic [31:0] bm, dm, rm;
        addr_base = 32'h300; data_base = 32'hC0;
        rdy_mode = 1'b1;
        run(32'h300, 32'h400, 16'd2, 16, 0, bm, dm, rm);
        rdy_mode = 1'b0;
        n_total++;
        if (stab_bad != 0 || stab_cmp != 8) $display("FAIL wait_stable: got bad=%0d cmp=%0d expected bad=0 cmp=8", stab_bad, stab_cmp);
        else n_pass++;
        n_total++;
        if (q_addr.size() != 4) $display("FAIL wait_count: got %0d expected 4", q_addr.size());
        else n_pass++;
        n_total++;
        if (q_addr.size() == 4 && (q_addr[3] !== 32'h404 || q_data[3] !== 32'hC1 || q_data[1] !== 32'hC0))
            $display("FAIL wait_writes: got %h/%h %h expected 00000404/000000c1 000000c0", q_addr[3], q_data[3], q_data[1]);
        else n_pass++;
        n_total++;
        if (dm !== (32'h1 << 13)) $display("FAIL wait_done: got %h expected 00002000", dm);
        else n_pass++;
    endtask

    task automatic test_zero_len;
        logic [31:0] bm, dm, rm;
        run(32'h100, 32'h200, 16'd0, 4, 0, bm, dm, rm);
        n_total++;
        if (dm !== 32'h2) $display("FAIL zero_done: got %h expected 00000002", dm);
        else n_pass++;
        n_total++;
        if (bm !== 32'h0 || rm !== 32'h0) $display("FAIL zero_busy_req: got busy=%h req=%h expected 0/0", bm, rm);
        else n_pass++;
    endtask

    task automatic test_wrap;
        logic [31:0] bm, dm, rm;
        addr_base = 32'hFFFFFFFC; data_base = 32'h55;
        run(32'hFFFFFFFC, 32'h10, 16'd2, 6, 0, bm, dm, rm);
        n_total++;
        if (q_addr.size() != 4 || q_addr[2] !== 32'h0 || q_data[3] !== 32'h56 || q_addr[3] !== 32'h14)
            $display("FAIL wrap_addr: got n=%0d rd2=%h wr2=%h expected n=4 rd2=00000000 wr2=00000014",
                     q_addr.size(), (q_addr.size() > 2) ? q_addr[2] : 32'hx, (q_addr.size() > 3) ? q_addr[3] : 32'hx);
        else n_pass++;
        n_total++;
        if (dm !== 32'h20) $display("FAIL wrap_done: got %h expected 00000020", dm);
        else n_pass++;
    endtask

    task automatic test_abort;
        logic [31:0] bm, dm, rm;
        int nw;
        addr_base = 32'h500; data_base = 32'hE0;
        run(32'h500, 32'h600, 16'd5, 8, 3, bm, dm, rm);
        nw = 0;
        foreach (q_we[i]) if (q_we[i]) nw++;
        n_total++;
        if (nw != 2 || q_addr.size() != 4) $display("FAIL abort_words: got writes=%0d xfers=%0d expected 2/4", nw, q_addr.size());
        else n_pass++;
        n_total++;
        if (dm !== 32'h20) $display("FAIL abort_done: got %h expected 00000020", dm);
        else n_pass++;
        // Abort while idle must not affect the next copy.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        addr_base = 32'h540; data_base = 32'h33;
        run(32'h540, 32'h640, 16'd1, 4, 0, bm, dm, rm);
        n_total++;
        if (q_addr.size() != 2 || dm !== 32'h8) $display("FAIL abort_idle: got xfers=%0d done=%h expected 2/00000008", q_addr.size(), dm);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] bm, dm, rm;
        addr_base = 32'h900; data_base = 32'h90;
        run(32'h900, 32'hA00, 16'd1, 3, 0, bm, dm, rm);
        // Now in cycle 3 (done visible): a start here must be ignored.
        start = 1'b1; len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (dm !== 32'h8 || busy !== 1'b0 || req !== 1'b0)
            $display("FAIL b2b_ignore: got done=%h busy=%b req=%b expected 00000008/0/0", dm, busy, req);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] bm, dm, rm;
        addr_base = 32'hB00; data_base = 32'h1234;
        rdy_mode = 1'b1;
        run(32'hB00, 32'hC00, 16'd3, 4, 0, bm, dm, rm);
        n_total++;
        if (rm[4] !== 1'b1 || we !== 1'b1) $display("FAIL rstmid_inwr: got req=%b we=%b expected 1/1", rm[4], we);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({req, we, busy, done} !== 4'b0000) $display("FAIL rstmid_drop: got %b expected 0000", {req, we, busy, done});
        else n_pass++;
        n_total++;
        if (addr !== 32'h0 || data_out !== 32'h0) $display("FAIL rstmid_bus: got addr=%h data_out=%h expected 0/0", addr, data_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        rdy_mode = 1'b0;
        addr_base = 32'h700; data_base = 32'h77;
        run(32'h700, 32'h800, 16'd1, 4, 0, bm, dm, rm);
        n_total++;
        if (q_addr.size() != 2 || q_addr[1] !== 32'h800 || q_data[1] !== 32'h77 || dm !== 32'h8)
            $display("FAIL rstmid_restart: got n=%0d done=%h expected n=2 wr 00000800=00000077 done=00000008", q_addr.size(), dm);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic_copy;
        test_rdy_wait;
        test_zero_len;
        test_wrap;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/limn2600_dma.md
LIMN2600_DMA -- requirements
Module: limn2600_dma

Interface
REQ-001 The module SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 The module SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-003 The module SHALL have port: start  input  1  one-cycle copy request; sampled only in IDLE.
REQ-004 The module SHALL have port: src  input  32  source byte address; bits[1:0] ignored.
REQ-005 The module SHALL have port: dst  input  32  destination byte address; bits[1:0] ignored.
REQ-006 The module SHALL have port: len  input  16  word count to copy.
REQ-007 The module SHALL have port: abort  input  1  ends an active copy after the current bus transfer.
REQ-008 The module SHALL have port: busy  output  1  high from the cycle after an accepted start until done.
REQ-009 The module SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 The module SHALL have port: req  output  1  bus transfer in progress.
REQ-011 The module SHALL have port: we  output  1  1 = write, 0 = read.
REQ-012 The module SHALL have port: addr  output  32  word-aligned bus address.
REQ-013 The module SHALL have port: data_out  output  32  write data to memory.
REQ-014 The module SHALL have port: data_in  input  32  read data from memory.
REQ-015 The module SHALL have port: rdy  input  1  memory completes the current transfer.

Function
REQ-016 Bus handshake SHALL work as follows: req, we, addr and data_out are registered and held stable while req=1; the transfer completes at the rising edge where req=1 and rdy=1; rdy when req=0 is ignored.
REQ-017 The state machine SHALL have states IDLE, RD, WR and DONE.
REQ-018 IDLE SHALL behave as follows: start=1 with len!=0 latches src[31:2], dst[31:2] and len, and goes to RD; start=1 with len=0 goes to DONE; start with busy=1 is ignored.
REQ-019 RD SHALL behave as follows: req=1, we=0, addr={src_ptr,2'b00}; on rdy, capture data_in into the hold register and go to WR.
REQ-020 WR SHALL behave as follows: req=1, we=1, addr={dst_ptr,2'b00}, data_out=hold; on rdy, increment both pointers by 1 word and decrement the count.
REQ-021 WR on rdy SHALL then go to DONE if the count reaches 0 or abort is pending, otherwise to RD.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, with busy=0 and req=0, then go to IDLE.
REQ-023 Latency SHALL be: start at edge N makes req=1 visible after edge N; with rdy tied high, one word costs 2 cycles, so len=L gives done in cycle 2L+1 after start.
REQ-024 Pointers SHALL be 30-bit and wrap modulo 2^30 words (0xFFFFFFFC+4 -> 0x00000000) with no error.
REQ-025 Abort SHALL be latched while busy; it never truncates a transfer mid-handshake.
REQ-026 Abort during RD SHALL still complete the pending write of that word before going to DONE.
REQ-027 Abort while not busy SHALL be ignored.
REQ-028 Overlapping source and destination regions SHALL be copied forward, word by word, with no hazard handling.
REQ-029 A start arriving in the same cycle as done SHALL be ignored; a new start is accepted only in IDLE.
REQ-030 When req=0, we SHALL be 0; addr and data_out hold their last values.

Reset
REQ-031 On rst low, regardless of clk, state SHALL be IDLE and busy, done, req and we SHALL be 0.
REQ-032 On rst low, addr, data_out, pointers, count, hold and abort flag SHALL be 0.
REQ-033 Reset mid-transfer SHALL drop req immediately; the memory's in-flight transfer is abandoned and not retried.
REQ-034 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Structure
REQ-035 Package limn2600_pkg SHALL hold the state encoding, WORD_BYTES=4, ADDR_W=32, DATA_W=32 and LEN_W=16.
REQ-036 One sub-module, limn2600_bus_master, SHALL own the req/we/addr/data_out registers and the rdy completion detect; limn2600_dma drives it via issue/complete strobes.

Verification
REQ-037 The bench SHALL cover: src=0x100, dst=0x200, len=3, rdy tied high, memory words 0xA0,0xA1,0xA2 -> writes to 0x200,0x204,0x208 with the same data, done in cycle 7, busy high in cycles 1-6.
REQ-038 The bench SHALL cover: rdy delayed 3 cycles per transfer, len=2 -> addr, we and data_out stable through every wait cycle; exactly 4 completed transfers.
REQ-039 The bench SHALL cover: len=0 start -> no req, done pulses in cycle 1, busy stays 0.
REQ-040 The bench SHALL cover: src=0xFFFFFFFC, dst=0x10, len=2 -> second read at addr 0x00000000.
REQ-041 The bench SHALL cover: abort asserted during the RD of word 2 of len=5 -> exactly 2 words written, then done.
REQ-042 The bench SHALL cover: rst pulled low while req=1 in WR -> req=0 and state IDLE immediately; a new start with len=1 then completes normally.
